// File: rtl/frame_input_pkg.sv
// Shared encodings and sizing helper for the frame input sequencer.
package frame_input_pkg;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_UP   = 2'd1,
        D_DOWN = 2'd2
    } dir_state_t;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_FIRE  = 2'd1,
        S_COOL  = 2'd2
    } shoot_state_t;

    function automatic int WIDTH_FOR(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_input_sequencer_btn_debounce.sv
// One button: 2-FF synchroniser followed by a stable-count debouncer.
module btn_debounce
    import frame_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CW = WIDTH_FOR(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample matching the stable level restarts the count from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_db = stable_q;

endmodule

// File: rtl/frame_input_sequencer.sv
// Conditions up/down/shoot buttons and schedules them into the game core
// inputs on vsync-derived frame boundaries.
module frame_input_sequencer
    import frame_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int COOLDOWN_FRAMES  = 8,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_shoot_raw,
    input  logic vsync_in,
    output logic move_up,
    output logic move_down,
    output logic shoot,
    output logic frame_tick
);

    localparam int CCW = (WIDTH_FOR(COOLDOWN_FRAMES) > 0) ? WIDTH_FOR(COOLDOWN_FRAMES) : 1;
    localparam logic [CCW-1:0] COOL_LOAD = CCW'(COOLDOWN_FRAMES);
    localparam logic [CCW-1:0] COOL_LAST = CCW'(1);

    logic up_db, down_db, shoot_db;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_up_raw), .btn_db(up_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_down_raw), .btn_db(down_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shoot (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_shoot_raw), .btn_db(shoot_db)
    );

    logic           vs1_q, vs2_q, vs3_q;
    logic           frame_tick_q, frame_tick_d;
    logic [2:0]     db_prev_q;
    dir_state_t     dir_q, dir_d;
    shoot_state_t   sh_q, sh_d;
    logic           pending_q, pending_d;
    logic [CCW-1:0] cool_q, cool_d;
    logic           move_up_q, move_up_d;
    logic           move_down_q, move_down_d;
    logic           shoot_q, shoot_d;
    logic           up_rise, down_rise, shoot_rise;

    always_comb begin
        up_rise    = up_db & ~db_prev_q[0];
        down_rise  = down_db & ~db_prev_q[1];
        shoot_rise = shoot_db & ~db_prev_q[2];

        frame_tick_d = VSYNC_ACTIVE_LOW ? (vs3_q & ~vs2_q) : (~vs3_q & vs2_q);

        // Last-pressed-wins; a simultaneous press favours up.
        dir_d = dir_q;
        if (up_rise) begin
            dir_d = D_UP;
        end else if (down_rise) begin
            dir_d = D_DOWN;
        end else if (dir_q == D_UP && !up_db) begin
            dir_d = down_db ? D_DOWN : D_IDLE;
        end else if (dir_q == D_DOWN && !down_db) begin
            dir_d = up_db ? D_UP : D_IDLE;
        end

        move_up_d   = move_up_q;
        move_down_d = move_down_q;
        if (frame_tick_q) begin
            move_up_d   = (dir_q == D_UP);
            move_down_d = (dir_q == D_DOWN);
        end

        sh_d      = sh_q;
        pending_d = pending_q;
        cool_d    = cool_q;
        shoot_d   = shoot_q;
        case (sh_q)
            S_READY: begin
                // A press landing on the tick cycle waits for the next tick.
                if (frame_tick_q && pending_q) begin
                    shoot_d   = 1'b1;
                    pending_d = 1'b0;
                    sh_d      = S_FIRE;
                end else if (shoot_rise) begin
                    pending_d = 1'b1;
                end
            end
            S_FIRE: begin
                if (frame_tick_q) begin
                    shoot_d = 1'b0;
                    cool_d  = COOL_LOAD;
                    sh_d    = (COOLDOWN_FRAMES == 0) ? S_READY : S_COOL;
                end
            end
            S_COOL: begin
                if (frame_tick_q) begin
                    cool_d = cool_q - 1'b1;
                    if (cool_q == COOL_LAST) begin
                        sh_d = S_READY;
                    end
                end
            end
            default: sh_d = S_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1_q        <= 1'b0;
            vs2_q        <= 1'b0;
            vs3_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            db_prev_q    <= 3'b000;
            dir_q        <= D_IDLE;
            sh_q         <= S_READY;
            pending_q    <= 1'b0;
            cool_q       <= '0;
            move_up_q    <= 1'b0;
            move_down_q  <= 1'b0;
            shoot_q      <= 1'b0;
        end else begin
            vs1_q        <= vsync_in;
            vs2_q        <= vs1_q;
            vs3_q        <= vs2_q;
            frame_tick_q <= frame_tick_d;
            db_prev_q    <= {shoot_db, down_db, up_db};
            dir_q        <= dir_d;
            sh_q         <= sh_d;
            pending_q    <= pending_d;
            cool_q       <= cool_d;
            move_up_q    <= move_up_d;
            move_down_q  <= move_down_d;
            shoot_q      <= shoot_d;
        end
    end

    assign move_up    = move_up_q;
    assign move_down  = move_down_q;
    assign shoot      = shoot_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_frame_input_sequencer.sv
// Bench for frame_input_sequencer: two instances (cooldown 2 and 0) against a
// cycle-level reference model built from button history windows and press order.
module tb_frame_input_sequencer;

    localparam int DB     = 4;
    localparam int PERIOD = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_vec = 3'b000;
    logic       vsync_in = 1'b1;
    int         cyc = 0;

    logic move_up_a, move_down_a, shoot_a, frame_tick_a;
    logic move_up_b, move_down_b, shoot_b, frame_tick_b;

    always #5 clk = ~clk;

    frame_input_sequencer #(.DEBOUNCE_CYCLES(DB), .COOLDOWN_FRAMES(2), .VSYNC_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .btn_up_raw(btn_vec[0]), .btn_down_raw(btn_vec[1]), .btn_shoot_raw(btn_vec[2]),
        .vsync_in(vsync_in),
        .move_up(move_up_a), .move_down(move_down_a), .shoot(shoot_a), .frame_tick(frame_tick_a)
    );

    frame_input_sequencer #(.DEBOUNCE_CYCLES(DB), .COOLDOWN_FRAMES(0), .VSYNC_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .btn_up_raw(btn_vec[0]), .btn_down_raw(btn_vec[1]), .btn_shoot_raw(btn_vec[2]),
        .vsync_in(vsync_in),
        .move_up(move_up_b), .move_down(move_down_b), .shoot(shoot_b), .frame_tick(frame_tick_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0] h [0:15];
    logic       hv [0:3];
    logic [2:0] m_db, m_db_prev;
    logic       m_tick, m_up, m_dn;
    int         m_dir;
    int         st_up, st_dn, step_n;
    int         lock [0:1];
    logic       pend [0:1];
    logic       msh  [0:1];
    int         cool_cfg [0:1] = '{2, 0};
    logic [7:0] exp_q[$];

    task automatic model_reset();
        for (int k = 0; k < 16; k++) h[k] = 3'b000;
        for (int k = 0; k < 4; k++) hv[k] = 1'b0;
        m_db = 3'b000; m_db_prev = 3'b000;
        m_tick = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_dir = 0;
        st_up = -1; st_dn = -1;
        for (int i = 0; i < 2; i++) begin
            lock[i] = 0; pend[i] = 1'b0; msh[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [2:0] db_old, rise;
        logic       tk_old, all_diff, fired, up_ok, dn_ok;
        int         dir_old, lock_pre;
        step_n++;
        db_old  = m_db;
        tk_old  = m_tick;
        dir_old = m_dir;
        rise    = m_db & ~m_db_prev;
        for (int k = 15; k > 0; k--) h[k] = h[k-1];
        h[0] = btn_vec;
        for (int k = 3; k > 0; k--) hv[k] = hv[k-1];
        hv[0] = vsync_in;
        // A level flips once the synchronised input has disagreed for DB samples in a row.
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k < 2 + DB; k++) if (h[k][b] == db_old[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = ~db_old[b];
        end
        m_db_prev = db_old;
        m_tick = hv[3] & ~hv[2];
        if (tk_old) begin
            m_up = (dir_old == 1);
            m_dn = (dir_old == 2);
        end
        // Direction = most recently pressed button still held (tie goes to up).
        if (rise[0]) st_up = step_n;
        if (rise[1]) st_dn = step_n;
        up_ok = db_old[0] && (st_up >= 0);
        dn_ok = db_old[1] && (st_dn >= 0);
        if (up_ok && (!dn_ok || st_up >= st_dn)) m_dir = 1;
        else if (dn_ok) m_dir = 2;
        else m_dir = 0;
        for (int i = 0; i < 2; i++) begin
            lock_pre = lock[i];
            fired = 1'b0;
            if (tk_old) begin
                if (lock[i] > 0) begin
                    lock[i]--;
                    msh[i] = 1'b0;
                end else if (pend[i]) begin
                    msh[i]  = 1'b1;
                    pend[i] = 1'b0;
                    lock[i] = cool_cfg[i] + 1;
                    fired   = 1'b1;
                end
            end
            if (rise[2] && lock_pre == 0 && !fired) pend[i] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(8'h00);
        end else begin
            model_step();
            exp_q.push_back({m_up, m_dn, msh[0], m_tick, m_up, m_dn, msh[1], m_tick});
        end
    end

    // ---------------- scoreboard ----------------
    logic       cnt_en = 1'b0;
    int         sh_cnt_a = 0, sh_cnt_b = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("outs_cool2", 32'({move_up_a, move_down_a, shoot_a, frame_tick_a}), 32'(e[7:4]));
            check_eq("outs_cool0", 32'({move_up_b, move_down_b, shoot_b, frame_tick_b}), 32'(e[3:0]));
            check_eq("dir_exclusive", 32'(move_up_a & move_down_a), 32'd0);
        end
        if (cnt_en) begin
            if (shoot_a) sh_cnt_a++;
            if (shoot_b) sh_cnt_b++;
        end
    end

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        vsync_in = ((cyc % PERIOD) >= 4);
    endtask

    task automatic wait_cycles(input int k);
        for (int i = 0; i < k; i++) next_cycle();
    endtask

    function automatic logic [7:0] all_outs();
        return {move_up_a, move_down_a, shoot_a, frame_tick_a,
                move_up_b, move_down_b, shoot_b, frame_tick_b};
    endfunction

    int tmr [0:2];

    initial begin
        wait_cycles(5);
        check_eq("reset_state", 32'(all_outs()), 32'd0);
        rst_n = 1'b1;

        // Up press and release
        wait_cycles(5);
        btn_vec[0] = 1'b1;
        wait_cycles(350);
        check_eq("t1_up_held", 32'({move_up_a, move_down_a}), 32'd2);
        btn_vec[0] = 1'b0;
        wait_cycles(250);
        check_eq("t1_up_released", 32'({move_up_a, move_down_a}), 32'd0);

        // Chattering shoot never debounces
        sh_cnt_a = 0; sh_cnt_b = 0; cnt_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn_vec[2] = 1'b1; wait_cycles(2);
            btn_vec[2] = 1'b0; wait_cycles(2);
        end
        wait_cycles(300);
        cnt_en = 1'b0;
        check_eq("t2_no_shoot", 32'(sh_cnt_a + sh_cnt_b), 32'd0);

        // Held shoot fires for exactly one frame
        sh_cnt_a = 0; sh_cnt_b = 0; cnt_en = 1'b1;
        btn_vec[2] = 1'b1;
        wait_cycles(500);
        cnt_en = 1'b0;
        check_eq("t3_len_cool2", 32'(sh_cnt_a), 32'(PERIOD));
        check_eq("t3_len_cool0", 32'(sh_cnt_b), 32'(PERIOD));
        btn_vec[2] = 1'b0; wait_cycles(30);
        btn_vec[2] = 1'b1; wait_cycles(30);
        btn_vec[2] = 1'b0; wait_cycles(400);

        // Direction arbitration
        btn_vec[0] = 1'b1; wait_cycles(200);
        btn_vec[1] = 1'b1; wait_cycles(200);
        check_eq("t4_down_wins", 32'({move_up_a, move_down_a}), 32'd1);
        btn_vec[1] = 1'b0; wait_cycles(200);
        check_eq("t4_back_to_up", 32'({move_up_a, move_down_a}), 32'd2);
        btn_vec[0] = 1'b0; wait_cycles(200);
        check_eq("t4_idle", 32'({move_up_a, move_down_a}), 32'd0);
        btn_vec[1:0] = 2'b11; wait_cycles(200);
        check_eq("t4_both_up", 32'({move_up_a, move_down_a}), 32'd2);
        btn_vec[1:0] = 2'b00; wait_cycles(300);

        // Reset during cooldown
        btn_vec[0] = 1'b1; btn_vec[2] = 1'b1;
        wait_cycles(250);
        check_eq("t5_pre_up", 32'(move_up_a), 32'd1);
        check_eq("t5_pre_cool", 32'(shoot_a), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_clear", 32'(all_outs()), 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        sh_cnt_a = 0; cnt_en = 1'b1;
        wait_cycles(300);
        cnt_en = 1'b0;
        check_eq("t5_shot_after_reset", 32'(sh_cnt_a), 32'(PERIOD));
        btn_vec = 3'b000; wait_cycles(300);

        // Shoot pressed every frame
        for (int f = 0; f < 10; f++) begin
            btn_vec[2] = 1'b1; wait_cycles(20);
            btn_vec[2] = 1'b0; wait_cycles(80);
        end

        // Random stimulus with glitches and long holds
        for (int b = 0; b < 3; b++) tmr[b] = $urandom_range(1, 50);
        for (int i = 0; i < 6000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (tmr[b] == 0) begin
                    btn_vec[b] = ~btn_vec[b];
                    tmr[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(5, 300);
                end else begin
                    tmr[b]--;
                end
            end
            if (i == 3000) rst_n = 1'b0;
            if (i == 3003) rst_n = 1'b1;
            next_cycle();
        end
        wait_cycles(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_input_sequencer.md
Name: frame_input_sequencer

Overview:
- Conditions the three raw player buttons (up, down, shoot) and schedules them into the game core's ui_in[2:0] on frame boundaries.
- Per button: synchronise, then debounce.
- Up/down is arbitrated with last-pressed-wins; shoot is a one-frame pulse with a frame-count cooldown.
- Sits between the board pins and the game core, on the game clock; uses the game core's own vsync output as the frame reference.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced level changes (10 ms at 25 MHz).
- COOLDOWN_FRAMES, 8, frame ticks spent in cooldown after a shot, before the next shot is accepted; 0 allowed.
- VSYNC_ACTIVE_LOW, 1, 1 means a frame tick is taken on the falling edge of vsync; 0 means the rising edge.

Ports:
- clk  in  1  game pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up_raw  in  1  raw up button, asynchronous, active-high.
- btn_down_raw  in  1  raw down button, asynchronous, active-high.
- btn_shoot_raw  in  1  raw shoot button, asynchronous, active-high.
- vsync_in  in  1  vsync from the game core; treated as asynchronous.
- move_up  out  1  registered; drives ui_in[0].
- move_down  out  1  registered; drives ui_in[1].
- shoot  out  1  registered; drives ui_in[2].
- frame_tick  out  1  one-cycle pulse per frame (debug/monitor).

Behaviour:
Reset:
- Every flop clears to 0: move_up, move_down, shoot, frame_tick, synchronisers, debounce counters, debounced levels.
- Direction FSM resets to D_IDLE; shoot FSM resets to S_READY; the pending flag clears.
- Reset asserted mid-operation aborts any shot or cooldown immediately; no state survives.

Synchronisers:
- Each of the four inputs passes through a 2-FF synchroniser; synchroniser flops reset to 0.

Debounce (per button):
- Counter width is clog2(DEBOUNCE_CYCLES+1).
- While synced == stable: counter = 0.
- Otherwise: counter increments. When it reaches DEBOUNCE_CYCLES-1 with synced still differing, stable <= synced and counter <= 0.
- Any glitch back to the stable value clears the counter.
- Latency from a raw edge to a debounced change is DEBOUNCE_CYCLES+2 cycles.

Frame tick:
- Edge-detect the synced vsync (falling edge when VSYNC_ACTIVE_LOW=1, rising edge otherwise).
- frame_tick is high for exactly one cycle per detected edge.

Direction FSM (D_IDLE, D_UP, D_DOWN), evaluated every cycle on debounced levels:
- up rising edge goes to D_UP; down rising edge goes to D_DOWN.
- Both rising edges in the same cycle go to D_UP.
- Releasing the held direction while the other button is still held goes to the other direction; releasing with neither held goes to D_IDLE.
- move_up and move_down are loaded from the FSM state only in the frame_tick cycle and are stable for the whole frame.
- move_up and move_down are never both 1.

Shoot FSM (S_READY, S_FIRE, S_COOL):
- In S_READY, a debounced shoot rising edge sets pending. Holding the button does not re-set pending.
- On frame_tick in S_READY with pending set: shoot <= 1, clear pending, go to S_FIRE.
- On the next frame_tick: shoot <= 0 and load cool_cnt = COOLDOWN_FRAMES.
  - If COOLDOWN_FRAMES=0, go to S_READY.
  - Otherwise go to S_COOL.
- In S_COOL, cool_cnt decrements on each frame_tick; when it reaches 0, go to S_READY.
- Shoot edges seen in S_FIRE or S_COOL are discarded, not queued.
- A press and a frame_tick in the same cycle: the press counts for the following frame tick.
- shoot is high for exactly one frame period.

Decomposition:
- Shared package frame_input_pkg holds the direction-state and shoot-state encodings and the constant WIDTH_FOR(n) = clog2(n+1).
- One sub-module, btn_debounce (2-FF synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES), instantiated three times.
- Vsync synchronisation and edge detection stay in the top of this block.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2, vsync period 100 cycles):
1. Hold btn_up_raw high from cycle 10 -> debounced up at cycle 16. At the first frame_tick after that, move_up=1 and move_down=0 for the whole frame. Release the button -> move_up=0 at the next tick after debounce.
2. Toggle btn_shoot_raw 1/0 every 2 cycles for 40 cycles -> debounced shoot never changes; shoot stays 0 across 3 frames.
3. Press shoot once and hold for 5 frames -> shoot=1 for exactly one frame (100 cycles), then 0. A second press in the next frame is ignored; a press after 2 further ticks fires on the following tick.
4. Hold up, then press down while up is held -> move_down=1 next frame. Release down with up still held -> move_up=1. Both raw inputs rising in the same cycle -> move_up=1.
5. Assert rst_n=0 while in S_COOL with move_up=1 -> all outputs 0 asynchronously. After release, shoot is accepted immediately and the direction FSM is in D_IDLE.
6. COOLDOWN_FRAMES=0, shoot pressed every frame -> shoot alternates 1/0 on successive frames with no extra gap.
